// File: rtl/rr_arb4_sel_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// Sel/En feed the downstream 2-to-4 decoder's Din/En inputs.
interface rr_arb4_sel_if;
  logic [3:0] Req;
  logic       Done;
  logic [1:0] Sel;
  logic       En;
  logic       Timeout;

  modport master (output Req, Done, input Sel, En, Timeout);
  modport slave  (input Req, Done, output Sel, En, Timeout);
endinterface

// File: rtl/rr_arb4_sel.sv
// Four-requester round-robin arbiter with grant hold, forced release on
// timeout and a one-cycle guard gap between grants. All outputs registered.
module rr_arb4_sel #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input logic         Clk,
  input logic         Rst_n,
  rr_arb4_sel_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam bit               TO_EN    = (HOLD_MAX != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sel_r, sel_d;
  logic             en_r, en_d;
  logic             to_r, to_d;
  logic [1:0]       ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [1:0] win;
  logic       any_req;
  logic       done_rel, wd_rel, to_hit, rel;

  assign bus.Sel     = sel_r;
  assign bus.En      = en_r;
  assign bus.Timeout = to_r;

  // First requester at or after ptr; the descending loop lets the lowest offset win.
  always_comb begin
    win     = ptr;
    any_req = |bus.Req;
    for (int i = 3; i >= 0; i--) begin
      if (bus.Req[ptr + 2'(i)]) win = ptr + 2'(i);
    end
  end

  assign done_rel = bus.Done;
  assign wd_rel   = !bus.Req[sel_r];
  assign to_hit   = TO_EN && (cnt == HOLD_LIM);
  assign rel      = done_rel || wd_rel || to_hit;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      sel_r <= 2'd0;
      en_r  <= 1'b0;
      to_r  <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sel_r <= sel_d;
      en_r  <= en_d;
      to_r  <= to_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (rel)     state_nxt = GAP;
      GAP:     state_nxt = any_req ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    sel_d = sel_r;
    en_d  = en_r;
    to_d  = 1'b0;
    ptr_d = ptr;
    cnt_d = cnt;
    case (state)
      IDLE, GAP: begin
        en_d = 1'b0;
        if (any_req) begin
          sel_d = win;
          en_d  = 1'b1;
          cnt_d = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel) begin
          en_d  = 1'b0;
          ptr_d = sel_r + 2'd1;
          to_d  = to_hit && !done_rel && !wd_rel;
        end else begin
          en_d = 1'b1;
          if (cnt != CNT_SAT) cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        en_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arb4_sel.sv
// Directed bench for rr_arb4_sel: per-cycle vector table plus hand-written
// timeout, reset and disabled-timeout sequences.
module tb_rr_arb4_sel;

  logic Clk;
  logic Rst_n;

  rr_arb4_sel_if bus1 ();
  rr_arb4_sel_if bus2 ();

  rr_arb4_sel #(.HOLD_MAX(15), .CNT_W(4)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus1));
  rr_arb4_sel #(.HOLD_MAX(0),  .CNT_W(4)) dut0 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus2));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       en;
    logic [1:0] sel;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  int   nvec  = 0;
  int   nfail = 0;

  function automatic void add(input logic [3:0] r, input logic d,
                              input logic e, input logic [1:0] s, input logic t);
    vec_t v;
    v.req = r; v.done = d; v.en = e; v.sel = s; v.to = t;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic e_act, input logic [1:0] s_act,
                     input logic t_act, input logic e, input logic [1:0] s, input logic t);
    nvec++;
    if (e_act !== e || s_act !== s || t_act !== t) begin
      nfail++;
      $display("FAIL %s: got En=%b Sel=%0d Timeout=%b, want En=%b Sel=%0d Timeout=%b",
               name, e_act, s_act, t_act, e, s, t);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    // fairness and wrap with Done in each grant's first cycle
    add(4'hF,0,1,0,0); add(4'hF,1,0,0,0); add(4'hF,0,1,1,0); add(4'hF,1,0,1,0);
    add(4'hF,0,1,2,0); add(4'hF,1,0,2,0); add(4'hF,0,1,3,0); add(4'hF,1,0,3,0);
    add(4'hF,0,1,0,0); add(4'hF,1,0,0,0); add(4'hF,0,1,1,0); add(4'hF,1,0,1,0);
    add(4'h0,0,0,1,0);
    // single request, Sel retained after release
    add(4'h4,0,1,2,0); add(4'h4,1,0,2,0); add(4'h0,0,0,2,0);
    // move pointer to 1, then withdrawal and skip, other-bit changes ignored
    add(4'h1,0,1,0,0); add(4'h1,1,0,0,0);
    add(4'hA,0,1,1,0); add(4'h8,0,0,1,0); add(4'h8,0,1,3,0); add(4'h9,0,1,3,0);
    add(4'h1,0,0,3,0); add(4'h1,0,1,0,0); add(4'h1,1,0,0,0);
    add(4'h0,0,0,0,0); add(4'h0,1,0,0,0);

    Rst_n = 1'b0;
    bus1.Req = 4'h0; bus1.Done = 1'b0;
    bus2.Req = 4'h0; bus2.Done = 1'b0;
    #1;
    chk("reset_state", bus1.En, bus1.Sel, bus1.Timeout, 1'b0, 2'd0, 1'b0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < vecs.size(); i++) begin
      bus1.Req  = vecs[i].req;
      bus1.Done = vecs[i].done;
      step();
      chk($sformatf("vec%0d", i), bus1.En, bus1.Sel, bus1.Timeout,
          vecs[i].en, vecs[i].sel, vecs[i].to);
    end

    // timeout: 15 cycles of En, Timeout with the first gap cycle, then re-grant
    bus1.Req = 4'h1; bus1.Done = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      step();
      chk($sformatf("hold_c%0d", c), bus1.En, bus1.Sel, bus1.Timeout, 1'b1, 2'd0, 1'b0);
    end
    step();
    chk("timeout_pulse", bus1.En, bus1.Sel, bus1.Timeout, 1'b0, 2'd0, 1'b1);
    step();
    chk("regrant", bus1.En, bus1.Sel, bus1.Timeout, 1'b1, 2'd0, 1'b0);
    for (int c = 2; c <= 15; c++) begin
      step();
      chk($sformatf("hold2_c%0d", c), bus1.En, bus1.Sel, bus1.Timeout, 1'b1, 2'd0, 1'b0);
    end
    bus1.Done = 1'b1;
    step();
    chk("done_beats_timeout", bus1.En, bus1.Sel, bus1.Timeout, 1'b0, 2'd0, 1'b0);
    bus1.Done = 1'b0; bus1.Req = 4'h0;
    step();
    chk("back_to_idle", bus1.En, bus1.Sel, bus1.Timeout, 1'b0, 2'd0, 1'b0);

    // asynchronous reset mid-grant (pointer is 1 here, so Sel=0 proves it reset)
    bus1.Req = 4'h4;
    step();
    chk("pre_reset_grant", bus1.En, bus1.Sel, bus1.Timeout, 1'b1, 2'd2, 1'b0);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_reset", bus1.En, bus1.Sel, bus1.Timeout, 1'b0, 2'd0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1; bus1.Req = 4'hF;
    step();
    chk("first_after_reset", bus1.En, bus1.Sel, bus1.Timeout, 1'b1, 2'd0, 1'b0);
    bus1.Req = 4'h0;

    // disabled timeout: grant never force-released
    bus2.Req = 4'h8;
    for (int c = 1; c <= 100; c++) begin
      step();
      chk($sformatf("notimeout_c%0d", c), bus2.En, bus2.Sel, bus2.Timeout, 1'b1, 2'd3, 1'b0);
    end
    bus2.Req = 4'h0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
